alu_muldiv: RTL and testbench

//  Parametrised successor to the 32-bit single-cycle ALU. It keeps every existing

---
 rtl/alu_muldiv_if.sv | 28 ++
 rtl/alu_muldiv.sv | 164 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Operand/result bundle between the EX-stage controller and the ALU with its
// iterative multiply/divide unit.
interface alu_muldiv_if #(parameter int WIDTH = 32);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [4:0]       f;
    logic             start;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, shamt, f, start,
        input  y, zero, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  a, b, shamt, f, start,
        output y, zero, busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// WIDTH-bit single-cycle ALU plus an iterative (one bit per cycle) MIPS-style
// multiply/divide unit writing architectural HI/LO registers.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | combinational ops only; accepts mult/multu/div/divu/mthi/mtlo
// MUL   | shift-add on operand magnitudes, WIDTH iterations
// DIV   | restoring division on operand magnitudes, WIDTH iterations
// FIX   | apply result signs, write hi/lo, done pulse visible this cycle
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_muldiv_if.slave  bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int HALF = WIDTH / 2;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] work_hi, work_lo, opb;
    logic [SHW-1:0]   cnt;
    logic             is_div, neg_q, neg_r, dz_q;
    logic             busy_q, done_q, dvz_q;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic [WIDTH-1:0] y_c;

    always_comb begin
        signed_op = (bus.f == 5'h10) || (bus.f == 5'h12);
        a_neg     = signed_op & bus.a[WIDTH-1];
        b_neg     = signed_op & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;

        mul_sum   = work_lo[0] ? ({1'b0, work_hi} + {1'b0, opb}) : {1'b0, work_hi};

        // Partial remainder can reach WIDTH+1 bits after the shift; the top
        // bit alone guarantees it exceeds any WIDTH-bit divisor.
        rem_sh    = {work_hi, work_lo[WIDTH-1]};
        div_ge    = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= opb);
        div_diff  = rem_sh[WIDTH-1:0] - opb;

        prod      = {work_hi, work_lo};
        prod_fix  = neg_q ? -prod : prod;
        q_fix     = neg_q ? -work_lo : work_lo;
        r_fix     = neg_r ? -work_hi : work_hi;
    end

    always_comb begin
        y_c = '0;
        case (bus.f)
            5'h00: y_c = bus.a & bus.b;
            5'h01: y_c = bus.a | bus.b;
            5'h02: y_c = bus.a + bus.b;
            5'h03: y_c = bus.b << bus.shamt;
            5'h04: y_c = bus.a + ~bus.b;
            5'h05: y_c = bus.a | ~bus.b;
            5'h06: y_c = bus.a - bus.b;
            5'h07: y_c[0] = $signed(bus.a) < $signed(bus.b);
            5'h08: y_c = bus.b << HALF;
            5'h09: y_c = bus.a ^ bus.b;
            5'h0A: y_c[0] = $signed(bus.a) > $signed({WIDTH{1'b0}});
            5'h0B: y_c = bus.b >> bus.a[SHW-1:0];
            5'h0C: y_c = bus.b >> bus.shamt;
            5'h0D: y_c[0] = !($signed(bus.a) > $signed({WIDTH{1'b0}}));
            5'h14: y_c = hi_q;
            5'h15: y_c = lo_q;
            default: y_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            work_hi <= '0;
            work_lo <= '0;
            opb     <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dvz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.f)
                            5'h10, 5'h11, 5'h12, 5'h13: begin
                                state   <= bus.f[1] ? DIV : MUL;
                                is_div  <= bus.f[1];
                                work_hi <= '0;
                                work_lo <= a_mag;
                                opb     <= b_mag;
                                neg_q   <= a_neg ^ b_neg;
                                neg_r   <= a_neg;
                                dz_q    <= bus.f[1] & ~|bus.b;
                                cnt     <= CNT_LAST;
                                busy_q  <= 1'b1;
                            end
                            5'h16:   hi_q <= bus.a;
                            5'h17:   lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (state == MUL) begin
                        work_hi <= mul_sum[WIDTH:1];
                        work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                    end else begin
                        work_hi <= div_ge ? div_diff : rem_sh[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], div_ge};
                    end
                    if (cnt == '0) begin
                        state  <= FIX;
                        done_q <= 1'b1;
                        dvz_q  <= dz_q;
                    end else begin
                        cnt <= cnt - SHW'(1);
                    end
                end
                FIX: begin
                    if (is_div) begin
                        // Divide by zero leaves |a| as remainder; r_fix restores a.
                        lo_q <= dz_q ? {WIDTH{1'b1}} : q_fix;
                        hi_q <= r_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.y           = y_c;
    assign bus.zero        = ~|y_c;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dvz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32: combinational ops, mul/div results,
// latency, corner cases, start-while-busy and mid-operation reset.
module tb_alu_muldiv;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_muldiv_if #(.WIDTH(32)) bus ();

    alu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t comb_vecs [24] = '{
        '{5'h00, 32'hF0F01234, 32'h0FF0FF00, 5'd0,  32'h00F01200},
        '{5'h01, 32'hF0F01234, 32'h0FF0FF00, 5'd0,  32'hFFF0FF34},
        '{5'h02, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000},
        '{5'h03, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000},
        '{5'h04, 32'h00000005, 32'h00000003, 5'd0,  32'h00000001},
        '{5'h05, 32'h00000000, 32'hFFFF0000, 5'd0,  32'h0000FFFF},
        '{5'h06, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000},
        '{5'h07, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001},
        '{5'h07, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000},
        '{5'h07, 32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000001},
        '{5'h07, 32'h7FFFFFFF, 32'h80000000, 5'd0,  32'h00000000},
        '{5'h08, 32'h00000000, 32'h00001234, 5'd0,  32'h12340000},
        '{5'h09, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0,  32'hF00FF00F},
        '{5'h0A, 32'h00000000, 32'h00000000, 5'd0,  32'h00000000},
        '{5'h0A, 32'h00000001, 32'h00000000, 5'd0,  32'h00000001},
        '{5'h0A, 32'h80000000, 32'h00000000, 5'd0,  32'h00000000},
        '{5'h0B, 32'h00000024, 32'h80000000, 5'd0,  32'h08000000},
        '{5'h0C, 32'h00000000, 32'hF0000000, 5'd28, 32'h0000000F},
        '{5'h0D, 32'h00000000, 32'h00000000, 5'd0,  32'h00000001},
        '{5'h0D, 32'h00000005, 32'h00000000, 5'd0,  32'h00000000},
        '{5'h0D, 32'hFFFFFFFF, 32'h00000000, 5'd0,  32'h00000001},
        '{5'h10, 32'h0000FFFF, 32'h0000FFFF, 5'd0,  32'h00000000},
        '{5'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000000},
        '{5'h0E, 32'h00000001, 32'h00000001, 5'd0,  32'h00000000}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches a mul/div, scrambles the inputs, returns the cycle done was seen
    // (-1 if never) and leaves time in the first cycle with hi/lo valid.
    task automatic run_op(input logic [4:0] fc, input logic [31:0] av, input logic [31:0] bv,
                          output int dcyc, output logic dz, output logic busy_ok);
        bus.f = fc; bus.a = av; bus.b = bv; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.f = 5'h00; bus.a = $urandom; bus.b = $urandom;
        dcyc = -1; dz = 1'b0; busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                dcyc = n;
                dz = bus.div_by_zero;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic mul_div_case(input string name, input logic [4:0] fc,
                                input logic [31:0] av, input logic [31:0] bv,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                input logic exp_dz);
        int   dcyc;
        logic dz, busy_ok;
        run_op(fc, av, bv, dcyc, dz, busy_ok);
        checks++;
        if (dcyc !== 33) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected 33", name, dcyc);
        end
        checks++;
        if (busy_ok !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy: held=%b after=%b expected held=1 after=0", name, busy_ok, bus.busy);
        end
        checks++;
        if (dz !== exp_dz) begin
            failures++;
            $display("FAIL %s div_by_zero: got %b expected %b", name, dz, exp_dz);
        end
        checks++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin
            failures++;
            $display("FAIL %s hi/lo: got %h/%h expected %h/%h", name, bus.hi, bus.lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.f = 5'h15; bus.a = '0; bus.b = '0; bus.shamt = '0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0 ||
            bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.y !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h y=%h expected all zero",
                     bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo, bus.y);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_comb();
        for (int i = 0; i < 24; i++) begin
            bus.f = comb_vecs[i].f; bus.a = comb_vecs[i].a;
            bus.b = comb_vecs[i].b; bus.shamt = comb_vecs[i].sh;
            #1;
            checks++;
            if (bus.y !== comb_vecs[i].exp || bus.zero !== (comb_vecs[i].exp == 32'h0)) begin
                failures++;
                $display("FAIL comb[%0d] f=%h: got y=%h zero=%b expected y=%h zero=%b", i,
                         comb_vecs[i].f, bus.y, bus.zero, comb_vecs[i].exp, comb_vecs[i].exp == 32'h0);
            end
        end
        bus.shamt = '0;
        tick();
    endtask

    task automatic test_move();
        bus.f = 5'h16; bus.a = 32'hDEADBEEF; bus.start = 1'b1;
        tick();
        bus.f = 5'h17; bus.a = 32'h12345678;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.hi !== 32'hDEADBEEF || bus.lo !== 32'h12345678 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h busy=%b done=%b expected DEADBEEF/12345678/0/0",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
        bus.f = 5'h16; bus.a = 32'h00000001;
        tick();
        bus.f = 5'h14;
        #1;
        checks++;
        if (bus.y !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL mthi_no_start/read_hi: got %h expected DEADBEEF", bus.y);
        end
        bus.f = 5'h15;
        #1;
        checks++;
        if (bus.y !== 32'h12345678) begin
            failures++;
            $display("FAIL read_lo: got %h expected 12345678", bus.y);
        end
        tick();
    endtask

    task automatic test_mul();
        mul_div_case("multu_max", 5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        mul_div_case("mult_neg",  5'h10, 32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0);
        mul_div_case("mult_nn",   5'h10, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0);
        mul_div_case("multu_hi",  5'h11, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b0);
    endtask

    task automatic test_div();
        mul_div_case("div_m7_2",   5'h12, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        mul_div_case("divu_by0",   5'h13, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1);
        mul_div_case("div_min_m1", 5'h12, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        mul_div_case("divu_100_7", 5'h13, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        mul_div_case("div_7_m2",   5'h12, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        mul_div_case("div_m8_0",   5'h12, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1);
        mul_div_case("divu_max_1", 5'h13, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0);
    endtask

    task automatic test_back_to_back();
        int   n;
        int   dcyc;
        logic dz;
        bus.f = 5'h16; bus.a = 32'hAAAA5555; bus.start = 1'b1;
        tick();
        bus.f = 5'h10; bus.a = 32'd1000; bus.b = 32'd1000;
        tick();
        n = 1;
        bus.start = 1'b0; bus.f = 5'h00; bus.a = $urandom; bus.b = $urandom;
        while (n < 5) begin tick(); n++; end
        bus.f = 5'h13; bus.a = 32'd9; bus.b = 32'd0; bus.start = 1'b1;
        tick(); n++;
        bus.start = 1'b0; bus.f = 5'h00;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL restart_busy: got busy=%b done=%b expected 1/0", bus.busy, bus.done);
        end
        while (n < 10) begin tick(); n++; end
        bus.f = 5'h14;
        #1;
        checks++;
        if (bus.y !== 32'hAAAA5555) begin
            failures++;
            $display("FAIL read_old_hi: got %h expected AAAA5555", bus.y);
        end
        bus.f = 5'h16; bus.a = 32'h00012345; bus.start = 1'b1;
        tick(); n++;
        bus.start = 1'b0; bus.f = 5'h00;
        checks++;
        if (bus.hi !== 32'hAAAA5555) begin
            failures++;
            $display("FAIL mthi_while_busy: got hi=%h expected AAAA5555", bus.hi);
        end
        dcyc = -1; dz = 1'b0;
        while (n <= 40) begin
            if (bus.done === 1'b1) begin dcyc = n; dz = bus.div_by_zero; break; end
            tick(); n++;
        end
        tick();
        checks++;
        if (dcyc !== 33 || dz !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h000F4240) begin
            failures++;
            $display("FAIL back_to_back: got done_cycle=%0d dz=%b hi=%h lo=%h expected 33/0/00000000/000F4240",
                     dcyc, dz, bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid();
        int   n;
        logic saw_done;
        bus.f = 5'h16; bus.a = 32'h5A5A5A5A; bus.start = 1'b1;
        tick();
        bus.f = 5'h13; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        n = 1;
        bus.start = 1'b0; bus.f = 5'h00;
        while (n < 12) begin tick(); n++; end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op: got busy=%b hi=%h lo=%h done=%b expected 0/0/0/0",
                     bus.busy, bus.hi, bus.lo, bus.done);
        end
        tick();
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL no_done_after_reset: activity seen=%b expected 0", saw_done);
        end
        mul_div_case("divu_after_reset", 5'h13, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_comb();
        test_move();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
